// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states, default width and result field offsets.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_W    = 32;
    localparam int QUOT_LSB = 0;
    localparam int REM_LSB  = DIV_W;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    // rem_i is always below the divisor, so the shifted value fits in WIDTH+1 bits and
    // bit WIDTH+1 of the difference is an exact borrow.
    logic [WIDTH+1:0] diff;

    always_comb begin
        diff  = {rem_i, bit_i} - {2'b00, dvs_i};
        q_o   = ~diff[WIDTH+1];
        rem_o = diff[WIDTH+1] ? {rem_i[WIDTH-1:0], bit_i} : diff[WIDTH:0];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned) with a valid/ready operand channel and a one-cycle result pulse.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes at the accept edge instead of running the full CALC sequence.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend,
    input  logic [WIDTH-1:0]     s_axis_divisor,
    input  logic                 s_signed,
    input  logic                 cancel,
    output logic                 m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     prem_q, prem_d;
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   quo_fin, rem_fin;
    logic [WIDTH-1:0]   quo_out, rem_out;
`ifdef DIV_ZERO_FAST_EN
    logic [WIDTH-1:0]   zero_quo;
`endif

    assign s_axis_tready      = (state_q == IDLE) & ~cancel;
    assign m_axis_dout_tvalid = (state_q == DONE) & ~cancel;
    assign m_axis_dout_tdata  = dout_q;
    assign busy               = (state_q != IDLE);

    assign accept = s_axis_tvalid & s_axis_tready;

    // Magnitudes wrap modulo 2^WIDTH, so the most negative value stays as its unsigned self.
    always_comb begin
        a_neg = s_signed & s_axis_dividend[WIDTH-1];
        b_neg = s_signed & s_axis_divisor[WIDTH-1];
        a_mag = a_neg ? -s_axis_dividend : s_axis_dividend;
        b_mag = b_neg ? -s_axis_divisor  : s_axis_divisor;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (prem_q),
        .bit_i (quo_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        quo_fin = {quo_q[WIDTH-2:0], step_q};
        rem_fin = step_rem[WIDTH-1:0];
        quo_out = qneg_q ? -quo_fin : quo_fin;
        rem_out = rneg_q ? -rem_fin : rem_fin;
    end

`ifdef DIV_ZERO_FAST_EN
    assign zero_quo = a_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (s_axis_divisor == '0) begin
                        dout_d  = {s_axis_dividend, zero_quo};
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                prem_d = step_rem;
                quo_d  = quo_fin;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    dout_d  = {rem_out, quo_out};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush abandons the operation and leaves the last delivered result untouched.
        if (cancel) begin
            state_d = IDLE;
            dout_d  = dout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed corner cases plus randomized operands against an arithmetic reference model.
module tb_div_iter;

    localparam int W        = 32;
    localparam int LAT_FULL = W + 1;
`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = W + 1;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_dividend = '0;
    logic [W-1:0]  s_axis_divisor = '0;
    logic          s_signed = 1'b0;
    logic          cancel = 1'b0;
    logic          m_axis_dout_tvalid;
    logic [2*W-1:0] m_axis_dout_tdata;
    logic          busy;

    div_iter #(.WIDTH(W)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_dividend    (s_axis_dividend),
        .s_axis_divisor     (s_axis_divisor),
        .s_signed           (s_signed),
        .cancel             (cancel),
        .m_axis_dout_tvalid (m_axis_dout_tvalid),
        .m_axis_dout_tdata  (m_axis_dout_tdata),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] data;
        int             due;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: C-style truncating division on the integer values, divisor zero gives all-ones magnitude.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        longint sa, sb;
        logic [W-1:0] q, r;
        if (b == '0) begin
            r = a;
            q = (sg && a[W-1]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Monitor: every result pulse must match the oldest outstanding expectation, both value and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (m_axis_dout_tvalid) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got tdata 0x%0h, expected no result (cycle %0d)", m_axis_dout_tdata, cyc);
            end else begin
                e = sb_q.pop_front();
                $display("[TB] result r=0x%08h q=0x%08h at cycle %0d", m_axis_dout_tdata[2*W-1:W], m_axis_dout_tdata[W-1:0], cyc);
                check("result_data", 64'(m_axis_dout_tdata), 64'(e.data));
                check("result_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after the accept edge with tvalid still high.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input bit push, input logic [2*W-1:0] expv, input int lat, output int acc);
        exp_t e;
        s_axis_dividend = a;
        s_axis_divisor  = b;
        s_signed        = sg;
        s_axis_tvalid   = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (s_axis_tready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no tready in 200 cycles, expected accept (a=0x%0h b=0x%0h)", a, b);
        end else if (push) begin
            e.data = expv;
            e.due  = acc + lat;
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        s_axis_tvalid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int acc, acc2, busy_cnt;
        logic busy_first, busy_after;
        logic [W-1:0] a, b;
        logic sg;
        int gap;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tready", 64'(s_axis_tready), 64'd1);
        check("reset_tvalid", 64'(m_axis_dout_tvalid), 64'd0);
        check("reset_tdata", 64'(m_axis_dout_tdata), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Signed 7/2 with busy window
        issue(32'd7, 32'd2, 1'b1, 1'b1, {32'd1, 32'd3}, LAT_FULL, acc);
        s_axis_tvalid = 1'b0;
        busy_cnt   = 0;
        busy_first = busy;
        busy_after = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            if (busy) busy_cnt++;
            if (k == W + 2) busy_after = busy;
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
        check("busy_first", 64'(busy_first), 64'd1);
        check("busy_after_done", 64'(busy_after), 64'd0);

        // Back-to-back corner cases with tvalid held
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, LAT_FULL, acc);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, {32'h0, 32'h8000_0000}, LAT_FULL, acc2);
        check("initiation_interval", 64'(acc2 - acc), 64'(W + 2));
        issue(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, {32'hF, 32'h0FFF_FFFF}, LAT_FULL, acc);
        issue(32'hFFFF_FFFF, 32'h10, 1'b1, 1'b1, {32'hFFFF_FFFF, 32'h0}, LAT_FULL, acc);
        issue(32'd5, 32'd0, 1'b0, 1'b1, {32'd5, 32'hFFFF_FFFF}, LAT_ZERO, acc);
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, {32'hFFFF_FFFB, 32'h1}, LAT_ZERO, acc);
        drain();

        // Cancel in cycle 10 of CALC, then an immediate new operation
        issue(32'd1234, 32'd5, 1'b0, 1'b0, '0, LAT_FULL, acc);
        s_axis_tvalid = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        #1;
        check("cancel_tready", 64'(s_axis_tready), 64'd0);
        check("cancel_busy_same_cycle", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy_next", 64'(busy), 64'd0);
        check("cancel_tready_next", 64'(s_axis_tready), 64'd1);
        issue(32'd100, 32'd7, 1'b0, 1'b1, {32'd2, 32'd14}, LAT_FULL, acc);
        drain();

        // Cancel with tvalid in IDLE must not accept
        s_axis_dividend = 32'd9;
        s_axis_divisor  = 32'd3;
        s_axis_tvalid   = 1'b1;
        cancel          = 1'b1;
        @(posedge clk);
        #1;
        cancel        = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("cancel_idle_no_accept", 64'(busy), 64'd0);

        // Reset mid-CALC discards the operation
        issue(32'd1000, 32'd3, 1'b0, 1'b0, '0, LAT_FULL, acc);
        s_axis_tvalid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_tready", 64'(s_axis_tready), 64'd1);
        check("midreset_tvalid", 64'(m_axis_dout_tvalid), 64'd0);
        check("midreset_tdata", 64'(m_axis_dout_tdata), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);

        // Randomized operands
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'($urandom_range(0, 300));
                3: a = 32'h0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'h1;
                3: b = 32'($urandom_range(1, 40));
                4: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            sg = 1'($urandom_range(0, 1));
            issue(a, b, sg, 1'b1, model(a, b, sg), (b == '0) ? LAT_ZERO : LAT_FULL, acc);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                s_axis_tvalid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        drain();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
